// File: rtl/div_unit.sv
// Multi-cycle restoring divider for the EX stage: {remainder, quotient} after DATA_W+2 edges.
// Define DIV_SIGNED_EN to honour signed_div_i; otherwise every division is unsigned.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*DATA_W-1:0]  r_result;
  logic                 r_ready;

  // Datapath: dividend register doubles as the quotient shift register.
  logic [DATA_W-1:0]    r_dvd;
  logic [DATA_W-1:0]    r_dsr;
  logic [DATA_W-1:0]    r_rem;

  logic [DATA_W-1:0]    w_mag1;
  logic [DATA_W-1:0]    w_mag2;
  logic [DATA_W-1:0]    w_fin_q;
  logic [DATA_W-1:0]    w_fin_r;

`ifdef DIV_SIGNED_EN
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic                 w_sgn1;
  logic                 w_sgn2;

  function automatic logic [DATA_W-1:0] apply_sign(input logic signed [DATA_W-1:0] v,
                                                   input logic neg);
    apply_sign = neg ? -v : v;
  endfunction

  assign w_sgn1  = signed_div_i & opdata1_i[DATA_W-1];
  assign w_sgn2  = signed_div_i & opdata2_i[DATA_W-1];
  assign w_mag1  = apply_sign(opdata1_i, w_sgn1);
  assign w_mag2  = apply_sign(opdata2_i, w_sgn2);
  assign w_fin_q = apply_sign(r_dvd, r_neg_q);
  assign w_fin_r = apply_sign(r_rem, r_neg_r);

  always_ff @(posedge clk) begin
    if (r_state == FREE) begin
      r_neg_q <= w_sgn1 ^ w_sgn2;
      r_neg_r <= w_sgn1;
    end
  end
`else
  logic                 w_unused_sgn;

  assign w_unused_sgn = signed_div_i;
  assign w_mag1       = opdata1_i;
  assign w_mag2       = opdata2_i;
  assign w_fin_q      = r_dvd;
  assign w_fin_r      = r_rem;
`endif

  // Restoring step: trial-subtract divisor from {partial remainder, next dividend bit}.
  logic [DATA_W:0]      w_part;
  logic [DATA_W-1:0]    w_diff;
  logic                 w_qbit;
  logic [DATA_W-1:0]    w_rem_nxt;

  assign w_part    = {r_rem, r_dvd[DATA_W-1]};
  assign w_diff    = DATA_W'(w_part - {1'b0, r_dsr});
  assign w_qbit    = (w_part >= {1'b0, r_dsr});
  assign w_rem_nxt = w_qbit ? w_diff : w_part[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (r_state == FREE) begin
      r_dvd <= w_mag1;
      r_dsr <= w_mag2;
      r_rem <= '0;
    end else if (r_state == ON && r_cnt != LAST_CNT) begin
      r_dvd <= {r_dvd[DATA_W-2:0], w_qbit};
      r_rem <= w_rem_nxt;
    end
  end

  // Control: annul wins over start and over step completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= FREE;
      r_cnt    <= '0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        FREE: begin
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              r_state <= BYZERO;
            end else begin
              r_state <= ON;
              r_cnt   <= '0;
            end
          end
        end
        BYZERO: begin
          r_result <= '0;
          if (annul_i) begin
            r_state <= FREE;
            r_ready <= 1'b0;
          end else begin
            r_state <= END;
            r_ready <= 1'b1;
          end
        end
        ON: begin
          if (annul_i) begin
            r_state  <= FREE;
            r_result <= '0;
            r_ready  <= 1'b0;
          end else if (r_cnt != LAST_CNT) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_state  <= END;
            r_result <= {w_fin_r, w_fin_q};
            r_ready  <= 1'b1;
          end
        end
        END: begin
          if (!start_i) begin
            r_state  <= FREE;
            r_result <= '0;
            r_ready  <= 1'b0;
          end
        end
        default: begin
          r_state  <= FREE;
          r_result <= '0;
          r_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed corner cases plus randomized divisions against an arithmetic model.
module tb_div_unit;

  localparam int DW = 32;
`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           start_i;
  logic           annul_i;
  logic           signed_div_i;
  logic [DW-1:0]  opdata1_i;
  logic [DW-1:0]  opdata2_i;
  logic [2*DW-1:0] result_o;
  logic           ready_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic seen;

  always #5 clk = ~clk;

  div_unit #(.DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  // Reference: plain integer division; SV '/' truncates toward zero and '%' follows the dividend sign.
  function automatic logic [2*DW-1:0] ref_div(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic sgn);
    longint sa, sb, q, r;
    if (b == '0) return '0;
    if (sgn && SIGNED_EN) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[DW-1:0], q[DW-1:0]};
  endfunction

  task automatic check(input string tag, input logic [2*DW-1:0] obs, input logic [2*DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one division, scramble operands while busy, check latency, result, hold and release.
  task automatic run_div(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic sgn, input logic [2*DW-1:0] exp, input int hold);
    int edges;
    int lat;
    edges = 0;
    lat = (b == '0) ? 2 : DW + 2;
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = sgn;
    annul_i      = 1'b0;
    start_i      = 1'b1;
    do begin
      tick();
      edges++;
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = 1'($urandom_range(0, 1));
    end while (!ready_o && edges < 100);
    check({tag, " latency"}, 64'(edges), 64'(lat));
    check({tag, " result"}, result_o, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " hold ready"}, 64'(ready_o), 64'd1);
      check({tag, " hold result"}, result_o, exp);
    end
    start_i = 1'b0;
    tick();
    check({tag, " release ready"}, 64'(ready_o), 64'd0);
    check({tag, " release result"}, result_o, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic sgn;

    // Reset overrides a pending request
    rst = 1'b1; start_i = 1'b1; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = 32'd100; opdata2_i = 32'd7;
    repeat (3) tick();
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset result", result_o, 64'd0);
    rst = 1'b0;

    run_div("u100_7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 1);
    run_div("s-7_2", 32'hFFFFFFF9, 32'd2, 1'b1,
            SIGNED_EN ? 64'hFFFFFFFF_FFFFFFFD : 64'h00000001_7FFFFFFC, 0);
    run_div("s_minneg", 32'h80000000, 32'hFFFFFFFF, 1'b1,
            SIGNED_EN ? 64'h00000000_80000000 : 64'h80000000_00000000, 0);
    run_div("div0", 32'd5, 32'd0, 1'b0, 64'd0, 3);

    // Annul mid-division at edge 10, then an immediate new request
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
    seen = 1'b0;
    repeat (9) begin tick(); seen |= ready_o; end
    annul_i = 1'b1;
    tick();
    seen |= ready_o;
    check("annul ready never", 64'(seen), 64'd0);
    check("annul result", result_o, 64'd0);
    run_div("after_annul 9_3", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 0);

    // Annul while in the divide-by-zero path
    opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
    tick();
    annul_i = 1'b1;
    tick();
    check("annul byzero ready", 64'(ready_o), 64'd0);
    annul_i = 1'b0; start_i = 1'b0;
    tick();
    check("annul byzero idle", 64'(ready_o), 64'd0);

    // Start and annul together in FREE never launch
    opdata1_i = 32'd9; opdata2_i = 32'd3; start_i = 1'b1; annul_i = 1'b1;
    seen = 1'b0;
    repeat (40) begin tick(); seen |= ready_o; end
    check("start+annul idle", 64'(seen), 64'd0);
    run_div("post start+annul", 32'd1000, 32'd10, 1'b0, 64'h00000000_00000064, 0);

    // Reset at edge 20 of a running division
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1; annul_i = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    check("midreset ready", 64'(ready_o), 64'd0);
    check("midreset result", result_o, 64'd0);
    rst = 1'b0;
    run_div("post reset", 32'hDEADBEEF, 32'h00001234, 1'b0,
            ref_div(32'hDEADBEEF, 32'h00001234, 1'b0), 0);

    // Randomized divisions with corner-biased operands
    for (int i = 0; i < 30; i++) begin
      a   = $urandom;
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: b = '0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFFFFFF;
        3: begin a = 32'h80000000; b = $urandom; end
        default: b = $urandom;
      endcase
      run_div("rand", a, b, sgn, ref_div(a, b, sgn), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
